// File: rtl/brew_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : brew_arbiter_if
//  Description : Station/brewer signal bundle for brew_arbiter.
//                master = purchase stations / observer, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface brew_arbiter_if;
  logic       req0;
  logic       req1;
  logic       cup_drop;
  logic       heater;
  logic       serve0;
  logic       serve1;
  logic       busy;
  logic [1:0] pend0;
  logic [1:0] pend1;
  logic       refund0;
  logic       refund1;

  modport master (
    output req0, req1,
    input  cup_drop, heater, serve0, serve1, busy, pend0, pend1, refund0, refund1
  );

  modport slave (
    input  req0, req1,
    output cup_drop, heater, serve0, serve1, busy, pend0, pend1, refund0, refund1
  );
endinterface
`default_nettype wire

// File: rtl/brew_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : brew_arbiter
//  Description : Shares one coffee brewer between two purchase stations.
//                Credits (0..3 per station) are banked from request pulses;
//                round-robin grant in IDLE, then CUP -> BREW -> DONE phases
//                timed by an 8-bit down-counter.
//                Optional macro BREW_ARBITER_REFUND_EN: pulse refundN when a
//                request arrives against a full credit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module brew_arbiter #(
  parameter int CUP_CYCLES  = 2,
  parameter int BREW_CYCLES = 8
) (
  input  logic          clk,
  input  logic          reset,
  brew_arbiter_if.slave bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CUP  = 2'd1;
  localparam logic [1:0] c_BREW = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [7:0] c_CUP_LOAD  = 8'(CUP_CYCLES);
  localparam logic [7:0] c_BREW_LOAD = 8'(BREW_CYCLES);

  logic [1:0] r_state;
  logic [7:0] r_timer;
  logic       r_owner;   // station currently being served
  logic       r_last;    // station served most recently (1 after reset)
  logic [1:0] r_pend0;
  logic [1:0] r_pend1;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_inc0;
  logic w_inc1;

  // Round-robin grant; a tie goes to the station not served last.
  always_comb begin
    w_idle   = (r_state == c_IDLE);
    w_grant1 = w_idle && (r_pend1 != 2'd0) && ((r_pend0 == 2'd0) || (r_last == 1'b0));
    w_grant0 = w_idle && (r_pend0 != 2'd0) && !w_grant1;
    // A full counter still accepts a request when the same edge consumes a credit.
    w_inc0   = bus.req0 && ((r_pend0 != 2'd3) || w_grant0);
    w_inc1   = bus.req1 && ((r_pend1 != 2'd3) || w_grant1);
  end

  // Credit counters: simultaneous increment and decrement cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend0 <= 2'd0;
      r_pend1 <= 2'd0;
    end else begin
      if (w_inc0 && !w_grant0)
        r_pend0 <= r_pend0 + 2'd1;
      else if (!w_inc0 && w_grant0)
        r_pend0 <= r_pend0 - 2'd1;

      if (w_inc1 && !w_grant1)
        r_pend1 <= r_pend1 + 2'd1;
      else if (!w_inc1 && w_grant1)
        r_pend1 <= r_pend1 - 2'd1;
    end
  end

  // Phase sequencer; each timed phase ends on the cycle the counter reads 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_timer <= 8'd0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_owner <= w_grant1;
            r_timer <= c_CUP_LOAD;
            r_state <= c_CUP;
          end
        end
        c_CUP: begin
          if (r_timer == 8'd1) begin
            r_timer <= c_BREW_LOAD;
            r_state <= c_BREW;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        c_BREW: begin
          if (r_timer == 8'd1) begin
            r_timer <= 8'd0;
            r_state <= c_DONE;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        c_DONE: begin
          r_last  <= r_owner;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef BREW_ARBITER_REFUND_EN
  logic r_refund0;
  logic r_refund1;

  // Overflow request: full counter and no credit consumed on this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refund0 <= 1'b0;
      r_refund1 <= 1'b0;
    end else begin
      r_refund0 <= bus.req0 && (r_pend0 == 2'd3) && !w_grant0;
      r_refund1 <= bus.req1 && (r_pend1 == 2'd3) && !w_grant1;
    end
  end

  assign bus.refund0 = r_refund0;
  assign bus.refund1 = r_refund1;
`else
  assign bus.refund0 = 1'b0;
  assign bus.refund1 = 1'b0;
`endif

  // Outputs decode only registered state.
  assign bus.cup_drop = (r_state == c_CUP);
  assign bus.heater   = (r_state == c_BREW);
  assign bus.serve0   = (r_state == c_DONE) && (r_owner == 1'b0);
  assign bus.serve1   = (r_state == c_DONE) && (r_owner == 1'b1);
  assign bus.busy     = (r_state != c_IDLE);
  assign bus.pend0    = r_pend0;
  assign bus.pend1    = r_pend1;

endmodule
`default_nettype wire

// File: tb/tb_brew_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brew_arbiter
//  Description : Directed self-checking bench for brew_arbiter. Cycle n is the
//                interval after edge n, where edge 0 is the first edge after
//                reset is released. A second instance runs 1/1 phase timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brew_arbiter;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  brew_arbiter_if ba ();
  brew_arbiter_if bf ();

  brew_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ba.slave)
  );

  brew_arbiter #(
    .CUP_CYCLES  (1),
    .BREW_CYCLES (1)
  ) dut_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (bf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    ba.req0 = 1'b0;
    ba.req1 = 1'b0;
    bf.req0 = 1'b0;
    bf.req1 = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int s0_cnt;
    int s1_cnt;
    int rf_cnt;
    int rf_cyc;
    int exp_rf;
    logic [7:0] exp_p [5];

    n_assert = 0;
    n_fail   = 0;

    // ---- reset state -------------------------------------------------------
    do_reset();
    check("rst_cup",    ba.cup_drop, 8'd0);
    check("rst_heat",   ba.heater,   8'd0);
    check("rst_serve0", ba.serve0,   8'd0);
    check("rst_serve1", ba.serve1,   8'd0);
    check("rst_busy",   ba.busy,     8'd0);
    check("rst_pend0",  ba.pend0,    8'd0);
    check("rst_pend1",  ba.pend1,    8'd0);
    check("rst_ref0",   ba.refund0,  8'd0);
    check("rst_ref1",   ba.refund1,  8'd0);
    check("rst_fbusy",  bf.busy,     8'd0);

    // ---- single req0: CUP 1-2, BREW 3-10, DONE 11, IDLE 12 ------------------
    ba.req0 = 1'b1;
    step();
    ba.req0 = 1'b0;
    check("s1_pend0_c0", ba.pend0, 8'd1);
    check("s1_busy_c0",  ba.busy,  8'd0);
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("s1_cup_c%0d", c),   ba.cup_drop, 8'((c >= 1 && c <= 2) ? 1 : 0));
      check($sformatf("s1_heat_c%0d", c),  ba.heater,   8'((c >= 3 && c <= 10) ? 1 : 0));
      check($sformatf("s1_srv0_c%0d", c),  ba.serve0,   8'((c == 11) ? 1 : 0));
      check($sformatf("s1_srv1_c%0d", c),  ba.serve1,   8'd0);
      check($sformatf("s1_busy_c%0d", c),  ba.busy,     8'((c <= 11) ? 1 : 0));
      check($sformatf("s1_pend0_c%0d", c), ba.pend0,    8'd0);
    end

    // ---- tie after reset: station 0 first, station 1 twelve cycles later ---
    do_reset();
    ba.req0 = 1'b1;
    ba.req1 = 1'b1;
    step();
    ba.req0 = 1'b0;
    ba.req1 = 1'b0;
    check("s2_pend0_c0", ba.pend0, 8'd1);
    check("s2_pend1_c0", ba.pend1, 8'd1);
    for (int c = 1; c <= 25; c++) begin
      step();
      check($sformatf("s2_srv0_c%0d", c), ba.serve0,   8'((c == 11) ? 1 : 0));
      check($sformatf("s2_srv1_c%0d", c), ba.serve1,   8'((c == 23) ? 1 : 0));
      check($sformatf("s2_cup_c%0d", c),  ba.cup_drop, 8'(((c >= 1 && c <= 2) || (c >= 13 && c <= 14)) ? 1 : 0));
      check($sformatf("s2_busy_c%0d", c), ba.busy,     8'((c == 12 || c >= 24) ? 0 : 1));
      if (c == 12) check("s2_pend1_c12", ba.pend1, 8'd1);
      if (c == 13) check("s2_pend1_c13", ba.pend1, 8'd0);
    end

    // ---- five back-to-back req0: saturation, four serves, optional refund --
    do_reset();
    exp_p  = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd3};
    s0_cnt = 0;
    rf_cnt = 0;
    rf_cyc = -1;
    for (int k = 0; k < 5; k++) begin
      ba.req0 = 1'b1;
      step();
      check($sformatf("s3_pend0_c%0d", k), ba.pend0, exp_p[k]);
      if (ba.refund0 === 1'b1) begin rf_cnt++; rf_cyc = k; end
      if (ba.serve0 === 1'b1) s0_cnt++;
    end
    ba.req0 = 1'b0;
    for (int c = 5; c < 60; c++) begin
      step();
      if (ba.refund0 === 1'b1) begin rf_cnt++; rf_cyc = c; end
      if (ba.serve0 === 1'b1) s0_cnt++;
    end
`ifdef BREW_ARBITER_REFUND_EN
    exp_rf = 1;
    check("s3_refund_cycle", 8'(rf_cyc), 8'd4);
`else
    exp_rf = 0;
`endif
    check("s3_serve0_count", 8'(s0_cnt), 8'd4);
    check("s3_refund_count", 8'(rf_cnt), 8'(exp_rf));
    check("s3_pend0_end",    ba.pend0,   8'd0);
    check("s3_busy_end",     ba.busy,    8'd0);

    // ---- reset during BREW with two station-1 credits banked ---------------
    do_reset();
    ba.req0 = 1'b1;
    step();
    ba.req0 = 1'b0;
    ba.req1 = 1'b1;
    step();
    step();
    ba.req1 = 1'b0;
    check("s4_pend1_c2", ba.pend1, 8'd2);
    for (int c = 3; c <= 8; c++) step();
    check("s4_heat_c8",  ba.heater, 8'd1);
    check("s4_pend1_c8", ba.pend1,  8'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("s4_cup",    ba.cup_drop, 8'd0);
    check("s4_heat",   ba.heater,   8'd0);
    check("s4_serve0", ba.serve0,   8'd0);
    check("s4_serve1", ba.serve1,   8'd0);
    check("s4_busy",   ba.busy,     8'd0);
    check("s4_pend0",  ba.pend0,    8'd0);
    check("s4_pend1",  ba.pend1,    8'd0);
    s0_cnt = 0;
    s1_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ba.serve0 === 1'b1) s0_cnt++;
      if (ba.serve1 === 1'b1) s1_cnt++;
      check($sformatf("s4_idle_busy_%0d", c), ba.busy, 8'd0);
    end
    check("s4_no_serve0", 8'(s0_cnt), 8'd0);
    check("s4_no_serve1", 8'(s1_cnt), 8'd0);

    // ---- 1/1 timing, req1 held for four edges: serves at 3, 7, 11, 15 ------
    do_reset();
    bf.req1 = 1'b1;
    s1_cnt  = 0;
    for (int c = 0; c <= 18; c++) begin
      step();
      if (c == 3) bf.req1 = 1'b0;
      if (bf.serve1 === 1'b1) s1_cnt++;
      if (c == 0) check("s5_pend1_c0", bf.pend1, 8'd1);
      if (c == 3) check("s5_pend1_c3", bf.pend1, 8'd3);
      check($sformatf("s5_cup_c%0d", c),  bf.cup_drop, 8'((c % 4 == 1 && c <= 13) ? 1 : 0));
      check($sformatf("s5_heat_c%0d", c), bf.heater,   8'((c % 4 == 2 && c <= 14) ? 1 : 0));
      check($sformatf("s5_srv1_c%0d", c), bf.serve1,   8'((c % 4 == 3 && c <= 15) ? 1 : 0));
      check($sformatf("s5_srv0_c%0d", c), bf.serve0,   8'd0);
      check($sformatf("s5_ref1_c%0d", c), bf.refund1,  8'd0);
    end
    check("s5_serve1_count", 8'(s1_cnt), 8'd4);
    check("s5_pend1_end",    bf.pend1,   8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
